spi_reg_bank: RTL
=================

// Module: spi_reg_bank
// PURPOSE
//  Register bank sitting directly downstream of the SPI register-access slave.
//  Consumes its address/write-data/write-strobe, returns read data and the 8-bit
//  status byte shifted out at start of frame. Holds ID, control, W1C interrupt
//  status/mask and general config registers exported to the user design.
// PARAMETERS
//  ADDR_W    3      address width; must be >=3; 2**ADDR_W registers
//  REG_W     8      register width; must be >=2
//  ID_VALUE  8'hA5  read-only value at address 0 (zero-extended/truncated to REG_W)
// PORTS
//  clk           in   1                     system clock
//  rst           in   1                     synchronous reset, active-high
//  ena           in   1                     clock enable; 0 freezes all state
//  reg_addr      in   ADDR_W                register address from SPI slave
//  reg_wdata     in   REG_W                 write data from SPI slave
//  reg_wdata_dv  in   1                     1-cycle write strobe
//  reg_rdata     out  REG_W                 read data for reg_addr (combinational)
//  status        out  8                     status byte to SPI slave
//  irq_in        in   REG_W                 event pulses, one per IRQ bit
//  irq_o         out  1                     |(IRQ_STATUS & IRQ_MASK), registered
//  cfg_o         out  (2**ADDR_W-4)*REG_W   config regs 4..N-1; reg 4 in LSBs
// BEHAVIOUR
//  Reset: rst=1 at posedge clk clears CTRL, IRQ_STATUS, IRQ_MASK, all cfg
//   regs, err flag, write counter and irq_o. rst wins over ena and pending
//   strobes; mid-write reset discards the write.
//  ena=0: no state changes. irq_in pulses and strobes in that cycle are lost.
//  Register map:
//   0 ID          RO   reads ID_VALUE; writes rejected
//   1 CTRL        RW   bit0 LOCK. bit1 ERR_CLR: self-clearing, reads 0. Other bits RW.
//   2 IRQ_STATUS  W1C  bit i set by irq_in[i]; writing 1 clears bit i
//   3 IRQ_MASK    RW
//   4..N-1 CFG    RW   rejected while LOCK=1
//  Write acceptance: on posedge with ena=1 and reg_wdata_dv=1.
//   Accepted if target is 1, 2 or 3, or CFG with LOCK=0.
//   Accepted write updates its register at that edge; visible on reg_rdata
//   and cfg_o the next cycle.
//   Rejected (addr 0, or CFG while LOCK=1): register unchanged, ERR set.
//   Writes to CTRL are never locked, so LOCK can always be cleared.
//  ERR: sticky. Cleared by an accepted CTRL write with bit1=1. Set and clear
//   in the same cycle cannot occur (one write per cycle).
//  IRQ_STATUS next = (cur & ~w1c_mask) | irq_in.
//   w1c_mask = reg_wdata on accepted write to addr 2, else 0.
//   Event and clear on the same bit in the same cycle: set wins.
//  irq_o: registered. One cycle after IRQ_STATUS/IRQ_MASK change.
//  Write counter: 5-bit, +1 per accepted write only; wraps 31->0.
//  status = {irq_o, LOCK, ERR, wr_cnt[4:0]}. All registered, no comb paths.
//  reg_rdata: combinational mux on reg_addr from current register state.
//   Reads have no side effects.
//  Register widths: internal regs are REG_W.
// TESTING
//  Reset, then read addrs 0-7 -> 0xA5, 0, 0, 0, 0,0,0,0; status=0x00; irq_o=0
//  Write 0x3C to addr 5 -> next cycle reg_rdata@5=0x3C, cfg_o[15:8]=0x3C,
//   status=0x01
//  Write 0x01 to CTRL, then 0xFF to addr 4 -> cfg reg 4 unchanged; status=0x61
//   (LOCK, ERR, cnt=1). Write 0x02 to CTRL -> LOCK=0, ERR=0, status=0x02.
//   Write 0x11 to addr 0 -> ERR=1, ID still 0xA5.
//  Mask=0x04, pulse irq_in=0x04 -> IRQ_STATUS=0x04, irq_o=1 one cycle later.
//   Write 0x04 to addr 2 with irq_in[2]=1 same cycle -> bit stays 1.
//   Repeat without the pulse -> bit 0, then irq_o=0.
//  32 accepted writes -> wr_cnt wraps to 0. Rejected writes do not count.
//   ena=0 with dv=1 -> no change.
//  Assert rst on same cycle as a CFG write -> all regs 0, write dropped,
//   status=0x00

Source files
------------

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI register-access slave.
// Holds a read-only ID, a control register (LOCK / ERR_CLR), a W1C interrupt
// status register with its mask, and general config registers that are
// exported to the user design. It also produces the status byte that the
// SPI slave shifts out at the start of each frame.
module spi_reg_bank #(
  parameter int          ADDR_W   = 3,
  parameter int          REG_W    = 8,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic [ADDR_W-1:0]                     reg_addr,
  input  logic [REG_W-1:0]                      reg_wdata,
  input  logic                                  reg_wdata_dv,
  output logic [REG_W-1:0]                      reg_rdata,
  output logic [7:0]                            status,
  input  logic [REG_W-1:0]                      irq_in,
  output logic                                  irq_o,
  output logic [((2**ADDR_W)-4)*REG_W-1:0]      cfg_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_CFG  = NUM_REGS - 4;

  localparam logic [REG_W-1:0]  ID_REG      = REG_W'(ID_VALUE);
  localparam logic [REG_W-1:0]  ERR_CLR_BIT = REG_W'(2);

  localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_ST = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MK = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_CFG0   = ADDR_W'(4);

  // Register state
  logic [REG_W-1:0]         ctrl_q;
  logic [REG_W-1:0]         irq_status_q;
  logic [REG_W-1:0]         irq_mask_q;
  logic [NUM_CFG*REG_W-1:0] cfg_q;
  logic                     err_q;
  logic [4:0]               wr_cnt_q;
  logic                     irq_q;

  // Write decode results
  logic                     lock;
  logic                     wr_fire;
  logic                     is_cfg;
  logic                     wr_accept;
  logic                     wr_reject;
  logic                     ctrl_we;
  logic                     mask_we;
  logic [REG_W-1:0]         w1c_mask;
  logic [NUM_CFG-1:0]       cfg_we;

  assign lock = ctrl_q[0];

  // Classify the strobe: CTRL/IRQ regs always accept, CFG only while unlocked,
  // ID never. One write per cycle, so at most one register enable is active.
  always_comb begin
    wr_fire   = ena & reg_wdata_dv;
    is_cfg    = (reg_addr >= ADDR_CFG0);
    wr_accept = 1'b0;
    wr_reject = 1'b0;
    ctrl_we   = 1'b0;
    mask_we   = 1'b0;
    w1c_mask  = '0;
    cfg_we    = '0;
    if (wr_fire) begin
      if (reg_addr == ADDR_ID) begin
        wr_reject = 1'b1;
      end else if (reg_addr == ADDR_CTRL) begin
        wr_accept = 1'b1;
        ctrl_we   = 1'b1;
      end else if (reg_addr == ADDR_IRQ_ST) begin
        wr_accept = 1'b1;
        w1c_mask  = reg_wdata;
      end else if (reg_addr == ADDR_IRQ_MK) begin
        wr_accept = 1'b1;
        mask_we   = 1'b1;
      end else if (is_cfg && lock) begin
        wr_reject = 1'b1;
      end else begin
        wr_accept = 1'b1;
        for (int k = 0; k < NUM_CFG; k++) begin
          if (reg_addr == ADDR_W'(k + 4)) begin
            cfg_we[k] = 1'b1;
          end
        end
      end
    end
  end

  // Register updates; ERR_CLR is never stored so CTRL bit 1 always reads 0.
  // IRQ events take priority over a simultaneous W1C clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      cfg_q        <= '0;
      err_q        <= 1'b0;
      wr_cnt_q     <= '0;
      irq_q        <= 1'b0;
    end else if (ena) begin
      irq_status_q <= (irq_status_q & ~w1c_mask) | irq_in;
      irq_q        <= |(irq_status_q & irq_mask_q);
      if (ctrl_we) begin
        ctrl_q <= reg_wdata & ~ERR_CLR_BIT;
      end
      if (mask_we) begin
        irq_mask_q <= reg_wdata;
      end
      for (int k = 0; k < NUM_CFG; k++) begin
        if (cfg_we[k]) begin
          cfg_q[k*REG_W +: REG_W] <= reg_wdata;
        end
      end
      if (wr_reject) begin
        err_q <= 1'b1;
      end else if (ctrl_we && reg_wdata[1]) begin
        err_q <= 1'b0;
      end
      if (wr_accept) begin
        wr_cnt_q <= wr_cnt_q + 5'd1;
      end
    end
  end

  // Read mux straight off the current register state; reads have no side effects.
  always_comb begin
    reg_rdata = '0;
    if (reg_addr == ADDR_ID) begin
      reg_rdata = ID_REG;
    end else if (reg_addr == ADDR_CTRL) begin
      reg_rdata = ctrl_q;
    end else if (reg_addr == ADDR_IRQ_ST) begin
      reg_rdata = irq_status_q;
    end else if (reg_addr == ADDR_IRQ_MK) begin
      reg_rdata = irq_mask_q;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (reg_addr == ADDR_W'(k + 4)) begin
          reg_rdata = cfg_q[k*REG_W +: REG_W];
        end
      end
    end
  end

  assign status = {irq_q, lock, err_q, wr_cnt_q};
  assign irq_o  = irq_q;
  assign cfg_o  = cfg_q;

endmodule
